// File: rtl/pid_alu_pkg.sv
// Shared types and helpers for the balance-controller arithmetic unit.
package pid_alu_pkg;

  typedef enum logic [1:0] {
    OP_ADD = 2'd0,
    OP_SUB = 2'd1,
    OP_MUL = 2'd2,
    OP_MAC = 2'd3
  } op_t;

  typedef enum logic [1:0] {
    SC_X1     = 2'd0,
    SC_X2     = 2'd1,
    SC_X4     = 2'd2,
    SC_X1_ALT = 2'd3
  } scale_t;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_EXEC = 2'd1,
    ST_MUL  = 2'd2,
    ST_ACC  = 2'd3
  } state_t;

  // Clamp a signed value into the range of a w-bit two's complement number.
  function automatic logic signed [63:0] sat_s(input logic signed [63:0] v,
                                               input int unsigned w);
    logic signed [63:0] hi;
    logic signed [63:0] lo;
    hi = (64'sd1 <<< (w - 32'd1)) - 64'sd1;
    lo = -(64'sd1 <<< (w - 32'd1));
    if (v > hi) begin
      sat_s = hi;
    end else if (v < lo) begin
      sat_s = lo;
    end else begin
      sat_s = v;
    end
  endfunction

endpackage

// File: rtl/pid_alu_seq_mult.sv
// Iterative signed shift-add multiplier: one multiplier bit per cycle,
// DW cycles from the start edge to the edge that raises o_done.
module seq_mult #(
  parameter int DW = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_start,
  input  logic [DW-1:0]     i_a,
  input  logic [DW-1:0]     i_b,
  output logic              o_done,
  output logic [2*DW-1:0]   o_prod
);

  localparam int CW = $clog2(DW) + 1;

  logic [2*DW-1:0] r_mcand;
  logic [DW-1:0]   r_mplier;
  logic [2*DW-1:0] r_prod;
  logic [CW-1:0]   r_cnt;
  logic            r_busy;
  logic            r_done;
  logic [2*DW-1:0] w_addend;

  // Partial product for the current multiplier bit.
  assign w_addend = r_mplier[0] ? r_mcand : {(2*DW){1'b0}};

  // Shift-add iteration; the multiplier sign bit carries negative weight,
  // so the last partial product is subtracted instead of added.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_mcand  <= '0;
      r_mplier <= '0;
      r_prod   <= '0;
      r_cnt    <= '0;
      r_busy   <= 1'b0;
      r_done   <= 1'b0;
    end else begin
      r_done <= 1'b0;
      if (!r_busy) begin
        if (i_start) begin
          r_mcand  <= {{DW{i_a[DW-1]}}, i_a};
          r_mplier <= i_b;
          r_prod   <= '0;
          r_cnt    <= '0;
          r_busy   <= 1'b1;
        end
      end else begin
        if (r_cnt == CW'(DW - 1)) begin
          r_prod <= r_prod - w_addend;
          r_busy <= 1'b0;
          r_done <= 1'b1;
        end else begin
          r_prod <= r_prod + w_addend;
        end
        r_mcand  <= {r_mcand[2*DW-2:0], 1'b0};
        r_mplier <= {1'b0, r_mplier[DW-1:1]};
        r_cnt    <= r_cnt + CW'(1);
      end
    end
  end

  assign o_done = r_done;
  assign o_prod = r_prod;

endmodule

// File: rtl/pid_alu_seq.sv
// Sequential ADD/SUB/MUL/MAC unit on signed fixed-point operands with an
// internal saturating accumulator.
module pid_alu_seq
  import pid_alu_pkg::*;
#(
  parameter int DW       = 16,
  parameter int FRAC     = 12,
  parameter int SAT_BITS = 12
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  input  logic [1:0]    op,
  input  logic [DW-1:0] a,
  input  logic [DW-1:0] b,
  input  logic [1:0]    scale,
  input  logic          saturate,
  input  logic          clr_acc,
  output logic          busy,
  output logic          done,
  output logic [DW-1:0] dst,
  output logic [DW-1:0] acc
);

  state_t                 r_state;
  op_t                    r_op;
  logic signed [DW-1:0]   r_a_s;
  logic signed [DW-1:0]   r_b;
  logic                   r_sat;
  logic signed [DW-1:0]   r_p;
  logic signed [DW-1:0]   r_acc;
  logic [DW-1:0]          r_dst;
  logic                   r_busy;
  logic                   r_done;

  logic [DW-1:0]          w_a_s;
  logic                   w_mult_start;
  logic                   w_mult_done;
  logic signed [2*DW-1:0] w_prod;
  logic signed [2*DW-1:0] w_shift;
  logic signed [DW-1:0]   w_p;
  logic signed [DW-1:0]   w_addsub;
  logic [DW-1:0]          w_addsub_res;
  logic signed [DW-1:0]   w_mac_res;

  // Scale src0 by a left shift; overflowed bits simply fall off.
  always_comb begin
    w_a_s = a;
    case (scale_t'(scale))
      SC_X2:   w_a_s = {a[DW-2:0], 1'b0};
      SC_X4:   w_a_s = {a[DW-3:0], 2'b00};
      default: w_a_s = a;
    endcase
  end

  assign w_mult_start = (r_state == ST_IDLE) && start && op[1];

  seq_mult #(.DW(DW)) u_mult (
    .clk     (clk),
    .rst     (rst),
    .i_start (w_mult_start),
    .i_a     (w_a_s),
    .i_b     (b),
    .o_done  (w_mult_done),
    .o_prod  (w_prod)
  );

  // Wrapped add/subtract, optionally clamped to the narrower SAT_BITS range.
  always_comb begin
    if (r_op == OP_SUB) begin
      w_addsub = r_b - r_a_s;
    end else begin
      w_addsub = r_b + r_a_s;
    end
    if (r_sat) begin
      w_addsub_res = DW'(sat_s(64'(w_addsub), SAT_BITS));
    end else begin
      w_addsub_res = w_addsub;
    end
  end

  // Arithmetic shift floors the fixed-point product before clamping.
  assign w_shift   = w_prod >>> FRAC;
  assign w_p       = DW'(sat_s(64'(w_shift), DW));
  assign w_mac_res = DW'(sat_s(64'(r_acc) + 64'(r_p), DW));

  // Control FSM with registered busy/done/dst and the accumulator.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= ST_IDLE;
      r_op    <= OP_ADD;
      r_a_s   <= '0;
      r_b     <= '0;
      r_sat   <= 1'b0;
      r_p     <= '0;
      r_acc   <= '0;
      r_dst   <= '0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (start) begin
            r_op    <= op_t'(op);
            r_a_s   <= w_a_s;
            r_b     <= b;
            r_sat   <= saturate;
            r_busy  <= 1'b1;
            r_state <= op[1] ? ST_MUL : ST_EXEC;
          end
        end
        ST_EXEC: begin
          r_dst   <= w_addsub_res;
          r_done  <= 1'b1;
          r_busy  <= 1'b0;
          r_state <= ST_IDLE;
        end
        ST_MUL: begin
          if (w_mult_done) begin
            if (r_op == OP_MAC) begin
              r_p     <= w_p;
              r_state <= ST_ACC;
            end else begin
              r_dst   <= w_p;
              r_done  <= 1'b1;
              r_busy  <= 1'b0;
              r_state <= ST_IDLE;
            end
          end
        end
        ST_ACC: begin
          r_acc   <= w_mac_res;
          r_dst   <= w_mac_res;
          r_done  <= 1'b1;
          r_busy  <= 1'b0;
          r_state <= ST_IDLE;
        end
        default: begin
          r_busy  <= 1'b0;
          r_state <= ST_IDLE;
        end
      endcase
      // A clear overrides any accumulator write on the same edge.
      if (clr_acc) begin
        r_acc <= '0;
      end
    end
  end

  assign busy = r_busy;
  assign done = r_done;
  assign dst  = r_dst;
  assign acc  = r_acc;

endmodule
